// File: rtl/tdm_demux_4ch.sv
// Receive end of a 4-channel word-interleaved TDM link: collects SOF-aligned frames and presents them registered.
// Optional macro TDM_DEMUX_TIMEOUT_EN aborts a stalled frame after 15 consecutive idle cycles.
module tdm_demux_4ch #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             sof_in,
    output logic [WIDTH-1:0] ch0_out,
    output logic [WIDTH-1:0] ch1_out,
    output logic [WIDTH-1:0] ch2_out,
    output logic [WIDTH-1:0] ch3_out,
    output logic             frame_valid_out,
    output logic             busy_out,
    output logic             err_out
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t           state;
    logic [1:0]       cnt;
    logic [WIDTH-1:0] sh [0:3];
`ifdef TDM_DEMUX_TIMEOUT_EN
    logic [3:0]       idle_cnt;
`endif

    assign busy_out = (state == COLLECT);

    // Channel 3 goes straight from data_in to ch3_out, so sh[3] only ever holds its reset value.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= IDLE;
            cnt             <= 2'd0;
            for (int i = 0; i < 4; i++) sh[i] <= '0;
            ch0_out         <= '0;
            ch1_out         <= '0;
            ch2_out         <= '0;
            ch3_out         <= '0;
            frame_valid_out <= 1'b0;
            err_out         <= 1'b0;
`ifdef TDM_DEMUX_TIMEOUT_EN
            idle_cnt        <= 4'd0;
`endif
        end else begin
            frame_valid_out <= 1'b0;
            err_out         <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        if (sof_in) begin
                            sh[0] <= data_in;
                            cnt   <= 2'd1;
                            state <= COLLECT;
`ifdef TDM_DEMUX_TIMEOUT_EN
                            idle_cnt <= 4'd0;
`endif
                        end else begin
                            err_out <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (valid_in) begin
`ifdef TDM_DEMUX_TIMEOUT_EN
                        idle_cnt <= 4'd0;
`endif
                        // A premature SOF drops the partial frame and restarts on the new one.
                        if (sof_in) begin
                            err_out <= 1'b1;
                            sh[0]   <= data_in;
                            cnt     <= 2'd1;
                        end else if (cnt == 2'd3) begin
                            ch0_out         <= sh[0];
                            ch1_out         <= sh[1];
                            ch2_out         <= sh[2];
                            ch3_out         <= data_in;
                            frame_valid_out <= 1'b1;
                            cnt             <= 2'd0;
                            state           <= IDLE;
                        end else begin
                            sh[cnt] <= data_in;
                            cnt     <= cnt + 2'd1;
                        end
                    end
`ifdef TDM_DEMUX_TIMEOUT_EN
                    // idle_cnt reads 14 on the 15th consecutive idle cycle.
                    else if (idle_cnt == 4'd14) begin
                        state    <= IDLE;
                        cnt      <= 2'd0;
                        err_out  <= 1'b1;
                        idle_cnt <= 4'd0;
                    end else begin
                        idle_cnt <= idle_cnt + 4'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Scoreboard bench for tdm_demux_4ch: stimulus pushes expected frame/error events, a monitor pops and compares them.
// Follows TDM_DEMUX_TIMEOUT_EN the same way as the design.
module tb_tdm_demux_4ch;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic [7:0] data_in = '0;
    logic       valid_in = 1'b0;
    logic       sof_in = 1'b0;
    logic [7:0] ch0_out, ch1_out, ch2_out, ch3_out;
    logic       frame_valid_out, busy_out, err_out;

    typedef struct {
        logic        is_err;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] held = '0;
    int          n_vec = 0;
    int          n_bad = 0;
    time         last_fv = 0;
    time         prev_fv = 0;

    tdm_demux_4ch #(.WIDTH(8)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .data_in         (data_in),
        .valid_in        (valid_in),
        .sof_in          (sof_in),
        .ch0_out         (ch0_out),
        .ch1_out         (ch1_out),
        .ch2_out         (ch2_out),
        .ch3_out         (ch3_out),
        .frame_valid_out (frame_valid_out),
        .busy_out        (busy_out),
        .err_out         (err_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] outs();
        return {ch0_out, ch1_out, ch2_out, ch3_out};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic push_frame(input logic [31:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = d;
        exp_q.push_back(e);
        held = d;
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = held;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d, input logic s);
        data_in  = d;
        sof_in   = s;
        valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        sof_in   = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        sof_in   = 1'b0;
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Every frame_valid/err pulse must match the oldest queued expectation.
    always @(negedge clk_in) begin
        if (rst_n_in && (frame_valid_out || err_out)) begin
            check("fv_err_exclusive", {31'd0, frame_valid_out & err_out}, 32'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_event: fv=%0b err=%0b outs=%h at %0t",
                         frame_valid_out, err_out, outs(), $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_kind_err", {31'd0, err_out}, {31'd0, e.is_err});
                check("event_outputs", outs(), e.data);
            end
            if (frame_valid_out) begin
                prev_fv = last_fv;
                last_fv = $time;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        check("reset_outputs", outs(), 32'h0);
        check("reset_flags", {29'd0, frame_valid_out, busy_out, err_out}, 32'd0);
        idle(1);
        rst_n_in = 1'b1;

        // Basic frame, consecutive words.
        push_frame(32'h11223344);
        send(8'h11, 1'b1);
        check("busy_after_sof", {31'd0, busy_out}, 32'd1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        check("busy_after_frame", {31'd0, busy_out}, 32'd0);
        check("frame_valid_latency", {31'd0, frame_valid_out}, 32'd1);
        idle(2);

        // Back-to-back frames, no bubble.
        push_frame(32'hA0A1A2A3);
        push_frame(32'hB0B1B2B3);
        send(8'hA0, 1'b1);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        send(8'hB0, 1'b1);
        send(8'hB1, 1'b0);
        send(8'hB2, 1'b0);
        check("hold_until_next_frame", outs(), 32'hA0A1A2A3);
        send(8'hB3, 1'b0);
        idle(2);
        check("back_to_back_spacing", 32'(last_fv - prev_fv), 32'd40);

        // Gap of 3 idle cycles mid-frame.
        push_frame(32'hC0C1C2C3);
        send(8'hC0, 1'b1);
        send(8'hC1, 1'b0);
        idle(3);
        check("busy_during_gap", {31'd0, busy_out}, 32'd1);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        idle(2);

        // Stray word in IDLE, then premature SOF resync.
        push_err();
        send(8'h55, 1'b0);
        idle(2);
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        push_err();
        push_frame(32'h10203040);
        send(8'h10, 1'b1);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        send(8'h40, 1'b0);
        idle(2);

        // Reset mid-frame clears everything immediately.
        send(8'h61, 1'b1);
        send(8'h62, 1'b0);
        rst_n_in = 1'b0;
        #1;
        held = '0;
        check("midframe_reset_outputs", outs(), 32'h0);
        check("midframe_reset_flags", {29'd0, frame_valid_out, busy_out, err_out}, 32'd0);
        idle(2);
        rst_n_in = 1'b1;
        push_frame(32'h71727374);
        send(8'h71, 1'b1);
        send(8'h72, 1'b0);
        send(8'h73, 1'b0);
        send(8'h74, 1'b0);
        idle(2);

        // Stall after SOF for 15 idle cycles.
`ifdef TDM_DEMUX_TIMEOUT_EN
        push_err();
        send(8'h99, 1'b1);
        idle(14);
        check("busy_before_timeout", {31'd0, busy_out}, 32'd1);
        idle(1);
        check("busy_after_timeout", {31'd0, busy_out}, 32'd0);
        idle(2);
`else
        push_frame(32'h99AABBCC);
        send(8'h99, 1'b1);
        idle(15);
        check("busy_no_timeout", {31'd0, busy_out}, 32'd1);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        idle(2);
`endif

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux_4ch.md
# tdm_demux_4ch

Time-division demultiplexer forming the receive end of a 4-channel word-interleaved link, whose transmit end is a select-driven multiplexer. It accepts a serial stream of words tagged with a start-of-frame marker, steers word k of each frame to channel k, and presents all four channels together, registered, once a complete frame has arrived. It sits between the link input and the per-channel consumers, flagging framing errors and resynchronising on them.

## Interface
Parameters:
- WIDTH, 8, data word width in bits.

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- data_in  input  WIDTH  incoming interleaved word.
- valid_in  input  1  data_in is valid this cycle.
- sof_in  input  1  qualifies data_in as channel 0, the first word of a frame; ignored when valid_in=0.
- ch0_out, ch1_out, ch2_out, ch3_out  output  WIDTH each  last complete frame, one word per channel.
- frame_valid_out  output  1  one-cycle pulse: ch*_out just updated.
- busy_out  output  1  frame collection in progress (state COLLECT).
- err_out  output  1  one-cycle pulse: framing error detected.

## Operation
- Reset: state IDLE, word counter cnt=0, shadow registers 0, ch0_out..ch3_out=0, frame_valid_out=0, busy_out=0, err_out=0.
- Four internal shadow registers sh[0..3]; 2-bit counter cnt indexes the next channel.
- IDLE:
  - valid_in&sof_in: sh[0]<=data_in, cnt<=1, go COLLECT.
  - valid_in&!sof_in: word discarded, err_out pulses, stay IDLE.
  - !valid_in: no action.
- COLLECT:
  - valid_in&!sof_in, cnt<3: sh[cnt]<=data_in, cnt<=cnt+1.
  - valid_in&!sof_in, cnt==3: chN_out<=sh[N] for N=0..2, ch3_out<=data_in, frame_valid_out pulses, cnt<=0, go IDLE.
  - valid_in&sof_in (premature SOF): err_out pulses; partial frame dropped, outputs unchanged; sh[0]<=data_in, cnt<=1, stay COLLECT (resync on the new frame).
  - !valid_in: hold; gaps of any length are allowed.
- busy_out = (state==COLLECT), registered with state.
- ch*_out change only on a completed frame and hold between frames; a partial frame never reaches the outputs.
- err_out and frame_valid_out are never high in the same cycle.

## Timing
- Last word (channel 3) sampled at edge N; ch*_out and frame_valid_out valid after edge N, i.e. 1-cycle latency from last word accepted.
- Back-to-back frames: SOF word on the cycle immediately after channel 3 is accepted in IDLE with no bubble; sustained throughput is one word per cycle.
- err_out is asserted the cycle after the offending word is sampled, and lasts one cycle.
- Reset asserted mid-frame: all state and outputs clear immediately, the partial frame is lost, and the next valid word must carry sof_in.

## Configuration
- TDM_DEMUX_TIMEOUT_EN defined: a 4-bit idle counter runs in COLLECT, cleared on every valid_in and on entry to COLLECT.
  - On the 15th consecutive cycle without valid_in: go IDLE, cnt<=0, err_out pulses, outputs unchanged.
- Not defined: no counter; COLLECT waits indefinitely for the rest of the frame.

## Test plan
- Reset, then 4 valid words 0x11(sof),0x22,0x33,0x44 on consecutive cycles -> ch0..3_out=0x11,0x22,0x33,0x44 and frame_valid_out=1 for one cycle, 1 cycle after 0x44; busy_out high during the frame.
- Two back-to-back frames A0..A3, B0..B3 with no gaps -> two frame_valid_out pulses 4 cycles apart; outputs hold A0..A3 until B completes.
- Frame with valid_in low for 3 cycles between words 1 and 2 -> correct channels, frame_valid_out 1 cycle after the last word, no err_out.
- Send 0x55 without sof in IDLE -> err_out pulse, outputs unchanged. Send 0x01(sof),0x02, then 0x10(sof),0x20,0x30,0x40 -> one err_out pulse, outputs become 0x10,0x20,0x30,0x40.
- Assert rst_n_in low after 2 words of a frame -> all outputs 0 immediately. Release, then send a full frame -> outputs update normally.
- With TDM_DEMUX_TIMEOUT_EN: sof word then 15 idle cycles -> err_out pulse, busy_out=0. Without it: same stimulus -> no err_out, and the frame completes when 3 more words arrive.
